// File: rtl/led_driver_pkg.sv
// Shared types and constants for the I2C bit-level target interface.
// ---------------------------------------------------------------------------
`default_nettype none

package led_driver_pkg;

   localparam int I2C_ADDR_BITS   = 7;
   localparam int I2C_SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_RX_BYTE  = 3'd3,
      ST_RX_ACK   = 3'd4,
      ST_TX_BYTE  = 3'd5,
      ST_TX_ACK   = 3'd6,
      ST_IGNORE   = 3'd7
   } phy_state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// Pin synchronizer (resets to idle-high) with single-cycle rise/fall pulses.
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], i_pin};
         r_prev <= r_sync[STAGES-1];
      end
   end

   assign o_level = r_sync[STAGES-1];
   assign o_rise  =  r_sync[STAGES-1] & ~r_prev;
   assign o_fall  = ~r_sync[STAGES-1] &  r_prev;

endmodule

`default_nettype wire

// File: rtl/i2c_bit_if.sv
// I2C target bit engine: address match, register-byte receive, single-byte read.
// Define I2C_CLK_STRETCH_EN to stretch SCL when the TX holder is empty at read start.
// ---------------------------------------------------------------------------
`default_nettype none

module i2c_bit_if
   import led_driver_pkg::*;
#(
   parameter logic [I2C_ADDR_BITS-1:0] DEVICE_ADDR = 7'h40,
   parameter int                       SYNC_STAGES = I2C_SYNC_STAGES
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic       scl_oe,
   output logic       start,
   output logic       stop,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   input  logic [7:0] tx_data,
   input  logic       tx_req,
   output logic       tx_ready,
   output logic       tx_underrun,
   output logic       busy
);

   logic w_scl, w_scl_rise, w_scl_fall;
   logic w_sda, w_sda_rise, w_sda_fall;
   logic w_start_det, w_stop_det;

   phy_state_t r_state;
   logic [2:0] r_bitcnt;
   logic [6:0] r_rx_shift;
   logic [6:0] r_tx_shift;
   logic [7:0] r_tx_hold;
   logic       r_tx_full;
   logic       r_tx_done;
   logic       r_rw;
   logic       r_reg_phase;
   logic       r_sda_oe;
   logic       r_start, r_stop, r_rx_valid, r_tx_underrun;
   logic [7:0] r_rx_data;
`ifdef I2C_CLK_STRETCH_EN
   logic       r_scl_oe;
   logic       r_tx_loaded;
`endif

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .clk(clk), .reset_n(reset_n), .i_pin(scl_in),
      .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
   );

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .clk(clk), .reset_n(reset_n), .i_pin(sda_in),
      .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
   );

   assign w_start_det = w_sda_fall & w_scl;
   assign w_stop_det  = w_sda_rise & w_scl;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_bitcnt      <= 3'd0;
         r_rx_shift    <= 7'd0;
         r_tx_shift    <= 7'd0;
         r_tx_hold     <= 8'd0;
         r_tx_full     <= 1'b0;
         r_tx_done     <= 1'b0;
         r_rw          <= 1'b0;
         r_reg_phase   <= 1'b0;
         r_sda_oe      <= 1'b0;
         r_start       <= 1'b0;
         r_stop        <= 1'b0;
         r_rx_valid    <= 1'b0;
         r_tx_underrun <= 1'b0;
         r_rx_data     <= 8'h00;
`ifdef I2C_CLK_STRETCH_EN
         r_scl_oe      <= 1'b0;
         r_tx_loaded   <= 1'b0;
`endif
      end else begin
         r_start       <= w_start_det;
         r_stop        <= w_stop_det;
         r_rx_valid    <= 1'b0;
         r_tx_underrun <= 1'b0;

         if (tx_req && !r_tx_full) begin
            r_tx_hold <= tx_data;
            r_tx_full <= 1'b1;
         end

         if (w_stop_det) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= 3'd0;
            r_sda_oe <= 1'b0;
`ifdef I2C_CLK_STRETCH_EN
            r_scl_oe    <= 1'b0;
            r_tx_loaded <= 1'b0;
`endif
         end else if (w_start_det) begin
            r_state   <= ST_ADDR;
            r_bitcnt  <= 3'd0;
            r_sda_oe  <= 1'b0;
            r_tx_done <= 1'b0;
`ifdef I2C_CLK_STRETCH_EN
            r_scl_oe    <= 1'b0;
            r_tx_loaded <= 1'b0;
`endif
         end else begin
            case (r_state)
               ST_ADDR, ST_RX_BYTE: begin
                  if (w_scl_rise) begin
                     r_rx_shift <= {r_rx_shift[5:0], w_sda};
                     r_bitcnt   <= r_bitcnt + 3'd1;
                     if (r_bitcnt == 3'd7) begin
                        r_rx_data  <= {r_rx_shift, w_sda};
                        r_rx_valid <= 1'b1;
                        if (r_state == ST_RX_BYTE) begin
                           r_state <= ST_RX_ACK;
                        end else if (r_rx_shift == DEVICE_ADDR) begin
                           r_rw        <= w_sda;
                           r_reg_phase <= 1'b1;
                           r_state     <= ST_ADDR_ACK;
                        end else begin
                           r_state <= ST_IGNORE;
                        end
                     end
                  end
               end
               // First falling edge starts the ACK drive, the second ends it.
               ST_ADDR_ACK, ST_RX_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_sda_oe) begin
                        r_sda_oe <= 1'b1;
                     end else if (r_state == ST_RX_ACK && r_reg_phase && r_rw) begin
                        r_reg_phase <= 1'b0;
                        r_state     <= ST_TX_BYTE;
                        if (r_tx_full) begin
                           r_tx_shift <= r_tx_hold[6:0];
                           r_tx_full  <= 1'b0;
                           r_sda_oe   <= ~r_tx_hold[7];
                        end else begin
                           r_sda_oe <= 1'b0;
`ifdef I2C_CLK_STRETCH_EN
                           r_scl_oe <= 1'b1;
`else
                           r_tx_shift    <= 7'h7F;
                           r_tx_underrun <= 1'b1;
`endif
                        end
                     end else begin
                        r_sda_oe <= 1'b0;
                        if (r_state == ST_RX_ACK) begin
                           r_reg_phase <= 1'b0;
                        end
                        r_state <= ST_RX_BYTE;
                     end
                  end
               end
               ST_TX_BYTE: begin
`ifdef I2C_CLK_STRETCH_EN
                  if (r_scl_oe) begin
                     if (r_tx_loaded) begin
                        r_scl_oe    <= 1'b0;
                        r_tx_loaded <= 1'b0;
                     end else if (r_tx_full) begin
                        r_tx_shift  <= r_tx_hold[6:0];
                        r_tx_full   <= 1'b0;
                        r_sda_oe    <= ~r_tx_hold[7];
                        r_tx_loaded <= 1'b1;
                     end
                  end else
`endif
                  if (w_scl_rise) begin
                     r_bitcnt <= r_bitcnt + 3'd1;
                     if (r_bitcnt == 3'd7) begin
                        r_tx_done <= 1'b1;
                     end
                  end else if (w_scl_fall) begin
                     if (r_tx_done) begin
                        r_tx_done <= 1'b0;
                        r_sda_oe  <= 1'b0;
                        r_state   <= ST_TX_ACK;
                     end else begin
                        r_tx_shift <= {r_tx_shift[5:0], 1'b0};
                        r_sda_oe   <= ~r_tx_shift[6];
                     end
                  end
               end
               ST_TX_ACK: begin
                  if (w_scl_rise) begin
                     r_state <= ST_IGNORE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sda_oe      = r_sda_oe;
`ifdef I2C_CLK_STRETCH_EN
   assign scl_oe      = r_scl_oe;
`else
   assign scl_oe      = 1'b0;
`endif
   assign start       = r_start;
   assign stop        = r_stop;
   assign rx_valid    = r_rx_valid;
   assign rx_data     = r_rx_data;
   assign tx_ready    = ~r_tx_full;
   assign tx_underrun = r_tx_underrun;
   assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire
